// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-requester AXI read arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package axi_arb_pkg;

    // Burst-level phases of the shared read port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    // Requester indices; the instruction cache is requester 0.
    localparam logic REQ_ICACHE = 1'b0;
    localparam logic REQ_DCACHE = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter that remembers the last granted index.
// Latency: grant is combinational from req_i; history updates on the clock edge.
// Backpressure: history only advances when en_i is high and a request is present.
module rr_arb2
    import axi_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic       grant_o,
    output logic       grant_vld_o
);

    logic last_grant_q;
    logic last_grant_d;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        grant_vld_o  = |req_i;
        if (&req_i) begin
            grant_o = ~last_grant_q;
        end else begin
            grant_o = req_i[1];
        end
        last_grant_d = last_grant_q;
        if (en_i && grant_vld_o) begin
            last_grant_d = grant_o;
        end
    end

    // Grant history; starts at the data cache so the instruction cache wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= REQ_DCACHE;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read master (AR/R) and snoop port (AC) between icache (0) and dcache (1).
// Latency: AR reaches the master 1 cycle after the request is seen in IDLE; R and AC are combinational.
// Backpressure: one burst in flight; owner's rready drives m_rready; m_acready waits for both caches.
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    // requester 0 (instruction cache)
    input  logic [ID_WIDTH-1:0]   s0_arid,
    input  logic [ADDR_WIDTH-1:0] s0_araddr,
    input  logic [7:0]            s0_arlen,
    input  logic [2:0]            s0_arsize,
    input  logic [1:0]            s0_arburst,
    input  logic                  s0_arlock,
    input  logic [3:0]            s0_arcache,
    input  logic [2:0]            s0_arprot,
    input  logic                  s0_arvalid,
    output logic                  s0_arready,
    output logic [ID_WIDTH-1:0]   s0_rid,
    output logic [DATA_WIDTH-1:0] s0_rdata,
    output logic [1:0]            s0_rresp,
    output logic                  s0_rlast,
    output logic                  s0_rvalid,
    input  logic                  s0_rready,
    output logic [ADDR_WIDTH-1:0] s0_acaddr,
    output logic [3:0]            s0_acsnoop,
    output logic                  s0_acvalid,
    input  logic                  s0_acready,
    // requester 1 (data cache)
    input  logic [ID_WIDTH-1:0]   s1_arid,
    input  logic [ADDR_WIDTH-1:0] s1_araddr,
    input  logic [7:0]            s1_arlen,
    input  logic [2:0]            s1_arsize,
    input  logic [1:0]            s1_arburst,
    input  logic                  s1_arlock,
    input  logic [3:0]            s1_arcache,
    input  logic [2:0]            s1_arprot,
    input  logic                  s1_arvalid,
    output logic                  s1_arready,
    output logic [ID_WIDTH-1:0]   s1_rid,
    output logic [DATA_WIDTH-1:0] s1_rdata,
    output logic [1:0]            s1_rresp,
    output logic                  s1_rlast,
    output logic                  s1_rvalid,
    input  logic                  s1_rready,
    output logic [ADDR_WIDTH-1:0] s1_acaddr,
    output logic [3:0]            s1_acsnoop,
    output logic                  s1_acvalid,
    input  logic                  s1_acready,
    // shared master port
    output logic [ID_WIDTH-1:0]   m_arid,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic                  m_arlock,
    output logic [3:0]            m_arcache,
    output logic [2:0]            m_arprot,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [ID_WIDTH-1:0]   m_rid,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [ADDR_WIDTH-1:0] m_acaddr,
    input  logic [3:0]            m_acsnoop,
    input  logic                  m_acvalid,
    output logic                  m_acready
);

    arb_state_t state_q, state_d;
    logic       owner_q, owner_d;
    logic [1:0] acked_q, acked_d;
    logic       arb_en;
    logic       grant;
    logic       grant_vld;

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .reset       (reset),
        .req_i       ({s1_arvalid, s0_arvalid}),
        .en_i        (arb_en),
        .grant_o     (grant),
        .grant_vld_o (grant_vld)
    );

    // Burst sequencing: arbitrate in IDLE, forward AR in ADDR, route beats in DATA.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        arb_en  = (state_q == IDLE);
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d = ADDR;
                    owner_d = grant;
                end
            end
            ADDR: begin
                if (m_arvalid && m_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (m_rvalid && m_rready && m_rlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // AR mux: only the owner's request is visible, and only while in ADDR.
    always_comb begin
        m_arid     = '0;
        m_araddr   = '0;
        m_arlen    = '0;
        m_arsize   = '0;
        m_arburst  = '0;
        m_arlock   = 1'b0;
        m_arcache  = '0;
        m_arprot   = '0;
        m_arvalid  = 1'b0;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        if (!reset && state_q == ADDR) begin
            if (owner_q == REQ_DCACHE) begin
                m_arid     = s1_arid;
                m_araddr   = s1_araddr;
                m_arlen    = s1_arlen;
                m_arsize   = s1_arsize;
                m_arburst  = s1_arburst;
                m_arlock   = s1_arlock;
                m_arcache  = s1_arcache;
                m_arprot   = s1_arprot;
                m_arvalid  = s1_arvalid;
                s1_arready = m_arready;
            end else begin
                m_arid     = s0_arid;
                m_araddr   = s0_araddr;
                m_arlen    = s0_arlen;
                m_arsize   = s0_arsize;
                m_arburst  = s0_arburst;
                m_arlock   = s0_arlock;
                m_arcache  = s0_arcache;
                m_arprot   = s0_arprot;
                m_arvalid  = s0_arvalid;
                s0_arready = m_arready;
            end
        end
    end

    // R routing: payload fans out to both caches, valid/ready only pair with the owner.
    always_comb begin
        s0_rid    = '0;
        s0_rdata  = '0;
        s0_rresp  = '0;
        s0_rlast  = 1'b0;
        s0_rvalid = 1'b0;
        s1_rid    = '0;
        s1_rdata  = '0;
        s1_rresp  = '0;
        s1_rlast  = 1'b0;
        s1_rvalid = 1'b0;
        m_rready  = 1'b0;
        if (!reset && state_q == DATA) begin
            s0_rid   = m_rid;
            s0_rdata = m_rdata;
            s0_rresp = m_rresp;
            s0_rlast = m_rlast;
            s1_rid   = m_rid;
            s1_rdata = m_rdata;
            s1_rresp = m_rresp;
            s1_rlast = m_rlast;
            if (owner_q == REQ_DCACHE) begin
                s1_rvalid = m_rvalid;
                m_rready  = s1_rready;
            end else begin
                s0_rvalid = m_rvalid;
                m_rready  = s0_rready;
            end
        end
    end

    // Snoop broadcast: each cache acks once; the master sees completion when both have.
    always_comb begin
        s0_acaddr  = m_acaddr;
        s0_acsnoop = m_acsnoop;
        s1_acaddr  = m_acaddr;
        s1_acsnoop = m_acsnoop;
        s0_acvalid = !reset && m_acvalid && !acked_q[0];
        s1_acvalid = !reset && m_acvalid && !acked_q[1];
        m_acready  = !reset && (acked_q[0] || s0_acready) && (acked_q[1] || s1_acready);
        if (m_acvalid && m_acready) begin
            acked_d = 2'b00;
        end else begin
            acked_d = acked_q | {s1_acvalid && s1_acready, s0_acvalid && s0_acready};
        end
    end

    // State, owner and snoop-ack registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= REQ_ICACHE;
            acked_q <= 2'b00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            acked_q <= acked_d;
        end
    end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Shares one AXI read master port (AR/R) and one snoop port (AC) between the instruction cache (requester 0) and the data cache (requester 1). It sits between the two cache controllers and the memory/interconnect port. Bursts are granted round-robin with one outstanding burst at a time, and read data is routed back to the granted requester. Snoop requests are broadcast to both caches, and each cache's handshake completes independently.

## Interface
Parameters:
- ID_WIDTH, 13: AXI ID width.
- ADDR_WIDTH, 64: AXI address width.
- DATA_WIDTH, 64: AXI read data width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s{0,1}_ar{id,addr,len,size,burst,lock,cache,prot}  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3  requester AR payload.
- s{0,1}_arvalid  in  1  requester AR valid.
- s{0,1}_arready  out  1  AR accepted.
- s{0,1}_r{id,data,resp,last}  out  ID_WIDTH/DATA_WIDTH/2/1  R payload, copied from the master.
- s{0,1}_rvalid  out  1  R valid to requester.
- s{0,1}_rready  in  1  requester R ready.
- s{0,1}_ac{addr,snoop}  out  ADDR_WIDTH/4  snoop payload, copied from the master.
- s{0,1}_acvalid  out  1  snoop valid to requester.
- s{0,1}_acready  in  1  requester snoop ready.
- m_ar{id,addr,len,size,burst,lock,cache,prot}, m_arvalid  out  as above  master AR.
- m_arready  in  1  master AR ready.
- m_r{id,data,resp,last}, m_rvalid  in  as above  master R.
- m_rready  out  1  master R ready.
- m_ac{addr,snoop}, m_acvalid  in  ADDR_WIDTH/4, 1  master snoop.
- m_acready  out  1  snoop complete.

## Operation
- State machine: IDLE, ADDR, DATA. The registers are `owner` (1 bit), `last_grant` (1 bit) and `acked[1:0]`.
- **IDLE:**
  - If any s_arvalid is high, grant a requester and go to ADDR.
  - If both are high, grant the requester != last_grant.
  - On grant, set owner = last_grant = granted index.
- **ADDR:**
  - m_ar* = s_owner_ar*, and m_arvalid = s_owner_arvalid.
  - s_owner_arready = m_arready; the other requester's arready is 0.
  - When m_arvalid && m_arready, go to DATA.
- **DATA:**
  - s_owner_rvalid = m_rvalid and m_rready = s_owner_rready; the other requester's rvalid is 0.
  - s_*_r payload is driven to both requesters.
  - On m_rvalid && m_rready && m_rlast, go to IDLE.
- All AR/R outputs not listed above for a state are 0. m_arid passes through unmodified; routing uses `owner` only.
- **Snoop:**
  - s_x_acvalid = m_acvalid && !acked[x].
  - m_acready = (acked[0] || s0_acready) && (acked[1] || s1_acready).
  - acked[x] sets on s_x_acvalid && s_x_acready without m_acready.
  - Both acked bits clear on m_acvalid && m_acready.
  - Snoop is independent of the AR/R state.

## Timing
- **Reset values:** state = IDLE, owner = 0, last_grant = 1 (so requester 0 wins the first tie), acked = 0.
- **Outputs during reset:** all valid/ready outputs are 0; s_acvalid and m_acready are forced to 0.
- **AR latency:** s_arvalid sampled at cycle t in IDLE gives m_arvalid at t+1. There is no combinational path from s_arvalid to m_arvalid in IDLE.
- **Back-to-back bursts:** after the rlast handshake (DATA to IDLE), the earliest next m_arvalid is 2 cycles later (one arbitration bubble).
- **Requester behaviour:** a requester must hold its AR payload stable while arvalid is high, per AXI. A requester that drops arvalid while in ADDR is a protocol violation and is not handled.
- **Backpressure:** an R beat with s_owner_rready = 0 stalls; m_rready stays 0 and the beat is held by the master.
- **Snoop latency:**
  - If both requesters are ready in the same cycle, m_acready is high in that cycle (combinational).
  - Otherwise the snoop completes in the cycle the last requester becomes ready.
- **Reset mid-burst:** returns to IDLE immediately. The remaining beats are the system's responsibility, since memory resets together.

## Structure
- Package `axi_arb_pkg`:
  - `arb_state_t` enum {IDLE, ADDR, DATA}.
  - Requester index constants `REQ_ICACHE` = 0 and `REQ_DCACHE` = 1.
- Sub-module `rr_arb2`: a 2-input round-robin arbiter that holds `last_grant`, with inputs req[1:0] and enable, and outputs grant index and grant valid.
- The AR/R muxing and snoop logic stay in the top module.

## Test plan
- Only s0_arvalid (araddr 0x1000, arlen 7) → m_arvalid rises 1 cycle later with m_araddr 0x1000. Eight R beats go to s0 only; s1_rvalid stays 0; state returns to IDLE after rlast.
- s0 and s1 arvalid together out of reset → s0 granted first, then s1. On a repeated simultaneous request the grant alternates s0, s1, s0.
- s1_rready low for 3 cycles mid-burst → m_rready is low for those 3 cycles, no beat is lost, and beat order is preserved.
- m_arready delayed 4 cycles → m_arvalid and the payload are held stable, and s_owner_arready pulses exactly once.
- Snoop with acsnoop 0xd: s0_acready = 1, s1_acready rising 2 cycles later → acked[0] sets, s0_acvalid drops, and m_acready pulses once in the cycle s1_acready rises.
- Reset asserted during beat 3 of a burst → next cycle is IDLE with all valid/ready outputs 0, and the next request is granted to s0.
